layer_sequencer: RTL and testbench

- Sequences one shared neuron datapath (with its neuron controller) through every neuron of every layer of the network.
- Issues a one-cycle start to the neuron controller and waits for its one-cycle ready.
- Commits each result to the layer output buffer, steps neuron and layer indices, and supplies the weight-memory base address.
- Sits between the top-level network start/done handshake and the per-neuron controller.

---
 rtl/nn_ctrl_pkg.sv | 18 +
 rtl/index_counter.sv | 29 ++
 rtl/layer_sequencer.sv | 112 +++++++++++
 tb/tb_layer_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the network sequencing logic: state encoding and
// an index-width helper that never returns a zero-width result.
package nn_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // Width needed to hold 0..x-1, at least one bit
    function automatic int clog2w(input int x);
        int w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/index_counter.sv
// Modulo-MOD index counter: synchronous clear, increment that wraps to zero
// after MOD-1, and a terminal-count flag while sitting at MOD-1.
module index_counter
    import nn_ctrl_pkg::*;
#(
    parameter int MOD = 8,
    parameter int W   = clog2w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MOD - 1));

    // Clear has priority; increment wraps at the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= tc ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks one shared neuron datapath over every neuron of every layer:
// launch neuron, wait for its result, commit it to the output buffer,
// advance indices and the weight base address, and flip the ping-pong
// buffer at each layer boundary.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_IN    = 10,
    parameter int N_NEUR  = 8,
    parameter int N_LAYER = 2,
    parameter int NW      = clog2w(N_NEUR),
    parameter int LW      = clog2w(N_LAYER),
    parameter int WB_W    = clog2w(N_LAYER * N_NEUR * N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            neuron_ready,
    output logic            neuron_start,
    output logic [NW-1:0]   neuron_idx,
    output logic [LW-1:0]   layer_idx,
    output logic [WB_W-1:0] wbase,
    output logic            out_we,
    output logic [NW-1:0]   out_addr,
    output logic            buf_sel,
    output logic            busy,
    output logic            done
);

    logic [2:0] state, state_nxt;
    logic       run_clr, n_inc, l_inc;
    logic       n_tc, l_tc, last_neuron;

    assign last_neuron = n_tc && l_tc;
    assign run_clr     = (state == IDLE) && start;
    assign n_inc       = (state == STORE) && !last_neuron;
    assign l_inc       = (state == STORE) && n_tc && !l_tc;
    assign out_addr    = neuron_idx;

    index_counter #(.MOD(N_NEUR), .W(NW)) u_neuron_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (n_inc),
        .cnt (neuron_idx),
        .tc  (n_tc)
    );

    index_counter #(.MOD(N_LAYER), .W(LW)) u_layer_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (l_inc),
        .cnt (layer_idx),
        .tc  (l_tc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; ready is only honoured in WAIT, start only in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (neuron_ready) state_nxt = STORE;
            STORE:   state_nxt = last_neuron ? DONE : LAUNCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        neuron_start = 1'b0;
        out_we       = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        case (state)
            LAUNCH: begin neuron_start = 1'b1; busy = 1'b1; end
            WAIT:   busy = 1'b1;
            STORE:  begin out_we = 1'b1; busy = 1'b1; end
            DONE:   begin done = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Running weight base: one N_IN step per committed neuron, held after the last
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wbase <= '0;
        else if (run_clr)
            wbase <= '0;
        else if (n_inc)
            wbase <= wbase + WB_W'(N_IN);
    end

    // Ping-pong select flips as each layer's final neuron is committed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            buf_sel <= 1'b0;
        else if ((state == STORE) && n_tc)
            buf_sel <= ~buf_sel;
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected launch,
// write and done events; a monitor pops and compares as the DUT emits them.
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, neuron_ready, m_ready, s_ready;
    logic       neuron_start, out_we, buf_sel, busy, done;
    logic [2:0] neuron_idx, out_addr;
    logic [0:0] layer_idx;
    logic [7:0] wbase;

    logic       start1, ready1;
    logic       neuron_start1, out_we1, buf_sel1, busy1, done1;
    logic [0:0] neuron_idx1, out_addr1, layer_idx1;
    logic [1:0] wbase1;

    assign neuron_ready = m_ready | s_ready;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .neuron_ready(neuron_ready),
        .neuron_start(neuron_start), .neuron_idx(neuron_idx), .layer_idx(layer_idx),
        .wbase(wbase), .out_we(out_we), .out_addr(out_addr), .buf_sel(buf_sel),
        .busy(busy), .done(done)
    );

    layer_sequencer #(.N_IN(4), .N_NEUR(1), .N_LAYER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .neuron_ready(ready1),
        .neuron_start(neuron_start1), .neuron_idx(neuron_idx1), .layer_idx(layer_idx1),
        .wbase(wbase1), .out_we(out_we1), .out_addr(out_addr1), .buf_sel(buf_sel1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int n; int l; int wb; int bs; } exp_t;
    exp_t s_q[$];
    exp_t w_q[$];
    int   d_q[$];

    int ncmp = 0;
    int nfail = 0;
    int lat_mode = 0;
    bit spur_en = 1'b0;
    int bs_exp = 0;
    int last_ready_cyc = -100;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        ncmp++;
        nfail++;
        $display("FAIL %s: event with no expectation (cyc %0d)", nm, cyc);
    endtask

    function automatic int outs();
        return int'({neuron_start, out_we, done, busy, buf_sel,
                     neuron_idx, layer_idx, wbase, out_addr});
    endfunction

    // Neuron controller model: ready pulse R cycles after each neuron_start
    initial begin
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (rst) pend = 1'b0;
            else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_ready = 1'b1;
                        pend = 1'b0;
                        last_ready_cyc = cyc;
                    end
                end
                if (neuron_start) begin
                    pend = 1'b1;
                    cnt = (lat_mode != 0) ? int'($urandom_range(3, 20)) : 11;
                end
            end
        end
    end

    // Spurious ready pulses while the DUT is in LAUNCH or STORE
    initial begin
        s_ready = 1'b0;
        forever begin
            @(negedge clk);
            s_ready = spur_en && (neuron_start || out_we);
        end
    end

    // Monitor: compare every launch, write and done against the scoreboard
    initial begin
        exp_t e;
        int d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (neuron_start) begin
                    if (s_q.size() == 0) flag("start_unexpected");
                    else begin
                        e = s_q.pop_front();
                        chk("start_nidx", int'(neuron_idx), e.n);
                        chk("start_layer", int'(layer_idx), e.l);
                        chk("start_wbase", int'(wbase), e.wb);
                        chk("start_bufsel", int'(buf_sel), e.bs);
                    end
                end
                if (out_we) begin
                    if (w_q.size() == 0) flag("we_unexpected");
                    else begin
                        e = w_q.pop_front();
                        chk("we_addr", int'(out_addr), e.n);
                        chk("we_layer", int'(layer_idx), e.l);
                        chk("we_wbase", int'(wbase), e.wb);
                        chk("we_bufsel", int'(buf_sel), e.bs);
                        chk("we_after_ready", cyc, last_ready_cyc + 1);
                    end
                end
                if (done) begin
                    if (d_q.size() == 0) flag("done_unexpected");
                    else begin
                        d = d_q.pop_front();
                        if (d >= 0) chk("done_cycle", cyc, d);
                        chk("done_busy", int'(busy), 1);
                    end
                end
            end
        end
    end

    // Queue a full default run and pulse (or hold) start
    task automatic run_full(input bit hold);
        exp_t e;
        int c0;
        for (int l = 0; l < 2; l++)
            for (int n = 0; n < 8; n++) begin
                e.n = n; e.l = l; e.wb = (l * 8 + n) * 10; e.bs = bs_exp ^ l;
                s_q.push_back(e);
                w_q.push_back(e);
            end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (!hold) start = 1'b0;
        d_q.push_back((lat_mode != 0) ? -1 : c0 + 208);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            ncmp++;
            nfail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else
            chk("bufsel_at_done", int'(buf_sel), bs_exp);
    endtask

    initial begin
        bit found;
        int c1, ns, nw, dp;
        rst = 1'b1; start = 1'b1; start1 = 1'b0; ready1 = 1'b0;

        // Reset with start asserted: everything held at zero
        repeat (3) @(negedge clk);
        chk("rst_outputs", outs(), 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
        end

        // Full run at fixed latency, exact done cycle
        lat_mode = 0;
        run_full(1'b0);
        wait_done(400);

        // Random per-neuron latency
        lat_mode = 1;
        run_full(1'b0);
        wait_done(1000);

        // Spurious ready in LAUNCH/STORE must not add writes or shorten the run
        lat_mode = 0;
        spur_en = 1'b1;
        run_full(1'b0);
        wait_done(400);
        spur_en = 1'b0;

        // Start held through the run, including DONE: only one run
        run_full(1'b1);
        wait_done(400);
        @(negedge clk);
        chk("idle_after_held_start", int'(busy), 0);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_rerun_busy", int'(busy), 0);
        end

        // Reset while waiting on layer 1, neuron 3
        run_full(1'b0);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (neuron_start && layer_idx == 1'b1 && neuron_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("found_l1_n3", int'(found), 1);
        @(negedge clk);
        chk("pre_rst_bufsel", int'(buf_sel), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", outs(), 0);
        s_q.delete();
        w_q.delete();
        d_q.delete();
        bs_exp = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", int'(busy), 0);
        end
        run_full(1'b0);
        wait_done(400);

        // Degenerate single-neuron, single-layer instance, R=11
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        c1 = cyc;
        start1 = 1'b0;
        ns = 0; nw = 0; dp = 0;
        for (int p = 1; p <= 20; p++) begin
            @(negedge clk);
            ready1 = (p == 12);
            if (neuron_start1) begin
                ns++;
                chk("deg_start_period", p, 1);
                chk("deg_start_wbase", int'(wbase1), 0);
            end
            if (out_we1) begin
                nw++;
                chk("deg_we_period", p, 13);
                chk("deg_we_addr", int'(out_addr1), 0);
            end
            if (done1) dp = cyc - c1 + 1;
        end
        ready1 = 1'b0;
        chk("deg_start_count", ns, 1);
        chk("deg_we_count", nw, 1);
        chk("deg_done_period", dp, 14);
        chk("deg_bufsel_end", int'(buf_sel1), 1);

        repeat (3) @(negedge clk);
        chk("leftover_starts", s_q.size(), 0);
        chk("leftover_writes", w_q.size(), 0);
        chk("leftover_dones", d_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
